// File: rtl/kernel_bram_pingpong_if.sv
// AXI-Stream sink bundle carrying one kernel channel vector per beat.
interface kernel_bram_pingpong_if #(
  parameter int unsigned DATA_WIDTH = 144
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready
  );
endinterface

// File: rtl/kernel_bram_pingpong.sv
// Double-buffered kernel store: one bank fills over AXI-Stream while the
// convolution datapath reads the other bank channel by channel.
module kernel_bram_pingpong #(
  parameter int unsigned KERNEL_WIDTH = 16,
  parameter int unsigned TAPS         = 9,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned CH_WIDTH     = 9
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [CH_WIDTH-1:0]          CHANNEL_SIZE,
  input  logic                         load_start,
  kernel_bram_pingpong_if.slave        axis,
  output logic                         load_done,
  input  logic                         update_BRAM_doutb,
  input  logic                         rd_rewind,
  output logic [TAPS*KERNEL_WIDTH-1:0] kernel_doutb,
  output logic                         doutb_valid,
  output logic                         last_channel,
  output logic                         set_done,
  output logic [1:0]                   bank_valid,
  output logic                         tlast_err,
  output logic                         cfg_err
);
  localparam int unsigned DW    = TAPS * KERNEL_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {W_IDLE, W_LOAD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_READY} rstate_t;

  wstate_t               wstate;
  rstate_t               rstate;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [CH_WIDTH-1:0]   size [2];
  logic [DW-1:0]         mem [0:2*DEPTH-1];

  logic beat;
  logic wr_final;
  logic rd_last;
  logic size_bad;

  assign axis.s_axis_tready = (wstate == W_LOAD);
  assign beat     = (wstate == W_LOAD) && axis.s_axis_tvalid;
  // Count compares rather than address wrap, so a full 2^ADDR_WIDTH set terminates.
  assign wr_final = (CH_WIDTH'(waddr) == size[wr_bank] - CH_WIDTH'(1));
  assign rd_last  = (CH_WIDTH'(raddr) == size[rd_bank] - CH_WIDTH'(1));
  assign size_bad = (CHANNEL_SIZE == '0) || (32'(CHANNEL_SIZE) > DEPTH);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      wstate       <= W_IDLE;
      rstate       <= R_IDLE;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      waddr        <= '0;
      raddr        <= '0;
      size[0]      <= '0;
      size[1]      <= '0;
      bank_valid   <= '0;
      load_done    <= 1'b0;
      set_done     <= 1'b0;
      doutb_valid  <= 1'b0;
      last_channel <= 1'b0;
      tlast_err    <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      load_done <= 1'b0;
      set_done  <= 1'b0;

      case (wstate)
        W_IDLE: begin
          if (load_start) begin
            if (size_bad) begin
              cfg_err <= 1'b1;
            end else if (!bank_valid[wr_bank]) begin
              size[wr_bank] <= CHANNEL_SIZE;
              waddr         <= '0;
              wstate        <= W_LOAD;
            end
          end
        end
        W_LOAD: begin
          if (axis.s_axis_tvalid) begin
            waddr <= waddr + 1'b1;
            if (axis.s_axis_tlast != wr_final) tlast_err <= 1'b1;
            if (wr_final) begin
              bank_valid[wr_bank] <= 1'b1;
              wr_bank             <= ~wr_bank;
              load_done           <= 1'b1;
              wstate              <= W_IDLE;
            end
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // The two FSMs only ever touch different bank_valid bits in one cycle.
      case (rstate)
        R_IDLE: begin
          if (bank_valid[rd_bank]) begin
            raddr  <= '0;
            rstate <= R_FETCH;
          end
        end
        R_FETCH: begin
          rstate       <= R_READY;
          doutb_valid  <= 1'b1;
          last_channel <= rd_last;
        end
        R_READY: begin
          if (update_BRAM_doutb) begin
            doutb_valid  <= 1'b0;
            last_channel <= 1'b0;
            if (!rd_last) begin
              raddr  <= raddr + 1'b1;
              rstate <= R_FETCH;
            end else if (rd_rewind) begin
              raddr  <= '0;
              rstate <= R_FETCH;
            end else begin
              bank_valid[rd_bank] <= 1'b0;
              set_done            <= 1'b1;
              rd_bank             <= ~rd_bank;
              raddr               <= '0;
              rstate              <= bank_valid[~rd_bank] ? R_FETCH : R_IDLE;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat && Reset) mem[{wr_bank, waddr}] <= axis.s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      kernel_doutb <= '0;
    end else if (rstate == R_FETCH) begin
      kernel_doutb <= mem[{rd_bank, raddr}];
    end
  end
endmodule

// File: tb/tb_kernel_bram_pingpong.sv
// Directed bench for kernel_bram_pingpong: a cycle table for a basic set,
// then hand-written sequences for ping-pong, stall, rewind, errors and reset.
module tb_kernel_bram_pingpong;
  localparam int unsigned KW = 16;
  localparam int unsigned TP = 9;
  localparam int unsigned DW = KW * TP;

  logic          clk;
  logic          Reset;
  logic [8:0]    CHANNEL_SIZE;
  logic          load_start;
  logic          load_done;
  logic          update_BRAM_doutb;
  logic          rd_rewind;
  logic [DW-1:0] kernel_doutb;
  logic          doutb_valid;
  logic          last_channel;
  logic          set_done;
  logic [1:0]    bank_valid;
  logic          tlast_err;
  logic          cfg_err;

  kernel_bram_pingpong_if #(.DATA_WIDTH(DW)) axis ();

  kernel_bram_pingpong #(
    .KERNEL_WIDTH(KW),
    .TAPS(TP),
    .ADDR_WIDTH(8),
    .CH_WIDTH(9)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .CHANNEL_SIZE(CHANNEL_SIZE),
    .load_start(load_start),
    .axis(axis),
    .load_done(load_done),
    .update_BRAM_doutb(update_BRAM_doutb),
    .rd_rewind(rd_rewind),
    .kernel_doutb(kernel_doutb),
    .doutb_valid(doutb_valid),
    .last_channel(last_channel),
    .set_done(set_done),
    .bank_valid(bank_valid),
    .tlast_err(tlast_err),
    .cfg_err(cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       ls;
    logic [8:0] sz;
    logic       tv;
    int         td;
    logic       tl;
    logic       adv;
    logic       rw;
    logic       tr;
    logic       ld;
    logic [1:0] bv;
    logic       dv;
    int         dq;
    logic       last;
    logic       sd;
  } vec_t;

  vec_t tbl [13];

  // Each tap carries a distinct value so every bit lane of a vector is exercised.
  function automatic logic [DW-1:0] mk(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(TP); i++) r[i*KW +: KW] = 16'(v + i);
    return r;
  endfunction

  function automatic vec_t v(input int ls, sz, tv, td, tl, adv, rw,
                             input int tr, ld, bv, dv, dq, last, sd);
    vec_t r;
    r.ls = ls[0]; r.sz = sz[8:0]; r.tv = tv[0]; r.td = td; r.tl = tl[0];
    r.adv = adv[0]; r.rw = rw[0];
    r.tr = tr[0]; r.ld = ld[0]; r.bv = bv[1:0]; r.dv = dv[0]; r.dq = dq;
    r.last = last[0]; r.sd = sd[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, DW'(act), DW'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int size, input int base, input int tlast_pos);
    bit ok;
    ok = 0;
    CHANNEL_SIZE = size[8:0];
    load_start = 1'b1;
    for (int n = 0; n < 60; n++) begin
      step();
      if (axis.s_axis_tready) begin ok = 1; break; end
    end
    load_start = 1'b0;
    chk1("load_accept", axis.s_axis_tready, 1'b1);
    if (!ok) return;
    for (int i = 0; i < size; i++) begin
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = mk(base + i);
      axis.s_axis_tlast  = (i == tlast_pos);
      step();
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    chk1("load_done", load_done, 1'b1);
    chk1("tready_after_load", axis.s_axis_tready, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 20; n++) begin
      if (doutb_valid) break;
      step();
    end
    chk1(name, doutb_valid, 1'b1);
  endtask

  task automatic read_chan(input int val, input logic is_last, input logic rw,
                           input logic exp_sd, input logic exp_next);
    chk1($sformatf("dv_before_%0d", val), doutb_valid, 1'b1);
    chk($sformatf("dout_%0d", val), kernel_doutb, mk(val));
    chk1($sformatf("last_%0d", val), last_channel, is_last);
    update_BRAM_doutb = 1'b1;
    rd_rewind = rw;
    step();
    update_BRAM_doutb = 1'b0;
    rd_rewind = 1'b0;
    chk1($sformatf("set_done_%0d", val), set_done, exp_sd);
    chk1($sformatf("dv_gap_%0d", val), doutb_valid, 1'b0);
    step();
    chk1($sformatf("dv_next_%0d", val), doutb_valid, exp_next);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".tready"}, axis.s_axis_tready, 1'b0);
    chk1({tag, ".load_done"}, load_done, 1'b0);
    chk({tag, ".bank_valid"}, DW'(bank_valid), '0);
    chk1({tag, ".dv"}, doutb_valid, 1'b0);
    chk({tag, ".dout"}, kernel_doutb, '0);
    chk1({tag, ".last"}, last_channel, 1'b0);
    chk1({tag, ".set_done"}, set_done, 1'b0);
    chk1({tag, ".tlast_err"}, tlast_err, 1'b0);
    chk1({tag, ".cfg_err"}, cfg_err, 1'b0);
  endtask

  initial begin
    Reset = 1'b0; CHANNEL_SIZE = '0; load_start = 1'b0;
    update_BRAM_doutb = 1'b0; rd_rewind = 1'b0;
    axis.s_axis_tdata = '0; axis.s_axis_tvalid = 1'b0; axis.s_axis_tlast = 1'b0;
    step(); step();
    chk_all_zero("reset");
    Reset = 1'b1;
    step();

    // Basic size-3 set; advances during R_IDLE/R_FETCH must be ignored.
    //          ls sz tv td tl adv rw | tr ld bv dv dq last sd
    tbl[0]  = v(1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 3, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 3, 1, 2, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 3, 1, 3, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0);
    tbl[4]  = v(0, 3, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = v(0, 3, 0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 0);
    tbl[6]  = v(0, 3, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0);
    tbl[7]  = v(0, 3, 0, 0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0);
    tbl[8]  = v(0, 3, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2, 0, 0);
    tbl[9]  = v(0, 3, 0, 0, 0, 1, 0,  0, 0, 1, 0, 2, 0, 0);
    tbl[10] = v(0, 3, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 1, 0);
    tbl[11] = v(0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 0, 3, 0, 1);
    tbl[12] = v(0, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0, 0);
    for (int i = 0; i < 13; i++) begin
      load_start = tbl[i].ls;
      CHANNEL_SIZE = tbl[i].sz;
      axis.s_axis_tvalid = tbl[i].tv;
      axis.s_axis_tdata = mk(tbl[i].td);
      axis.s_axis_tlast = tbl[i].tl;
      update_BRAM_doutb = tbl[i].adv;
      rd_rewind = tbl[i].rw;
      step();
      chk1($sformatf("t1[%0d].tready", i), axis.s_axis_tready, tbl[i].tr);
      chk1($sformatf("t1[%0d].load_done", i), load_done, tbl[i].ld);
      chk($sformatf("t1[%0d].bank_valid", i), DW'(bank_valid), DW'(tbl[i].bv));
      chk1($sformatf("t1[%0d].dv", i), doutb_valid, tbl[i].dv);
      chk($sformatf("t1[%0d].dout", i), kernel_doutb, (tbl[i].dq == 0) ? '0 : mk(tbl[i].dq));
      chk1($sformatf("t1[%0d].last", i), last_channel, tbl[i].last);
      chk1($sformatf("t1[%0d].set_done", i), set_done, tbl[i].sd);
    end
    load_start = 1'b0; axis.s_axis_tvalid = 1'b0; axis.s_axis_tlast = 1'b0;
    update_BRAM_doutb = 1'b0;

    // Ping-pong: A (size 4, bank 1) then B (size 2, bank 0) back to back.
    load(4, 10, 3);
    load(2, 20, 1);
    chk("pp.bank_valid", DW'(bank_valid), DW'(2'b11));
    wait_valid("pp.first_valid");
    read_chan(10, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(11, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(12, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(13, 1'b1, 1'b0, 1'b1, 1'b1);
    read_chan(20, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(21, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pp.bank_valid_end", DW'(bank_valid), '0);

    // Both banks full: a third load stalls until a bank is released.
    load(2, 30, 1);
    load(1, 40, 0);
    CHANNEL_SIZE = 9'd1;
    load_start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk1($sformatf("stall.tready_%0d", n), axis.s_axis_tready, 1'b0);
    end
    wait_valid("stall.c_valid");
    read_chan(30, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(31, 1'b1, 1'b0, 1'b1, 1'b1);
    load(1, 50, 0);
    read_chan(40, 1'b1, 1'b0, 1'b1, 1'b1);
    read_chan(50, 1'b1, 1'b0, 1'b1, 1'b0);

    // Rewind three times, then release.
    load(2, 60, 1);
    wait_valid("rw.first_valid");
    for (int k = 0; k < 3; k++) begin
      read_chan(60, 1'b0, 1'b0, 1'b0, 1'b1);
      read_chan(61, 1'b1, 1'b1, 1'b0, 1'b1);
      chk($sformatf("rw.bank_valid_%0d", k), DW'(bank_valid), DW'(2'b01));
    end
    read_chan(60, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(61, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rw.bank_valid_end", DW'(bank_valid), '0);

    // Early tlast flags an error but the count still governs completion.
    chk1("tlast_err_before", tlast_err, 1'b0);
    load(3, 80, 0);
    chk1("tlast_err_after", tlast_err, 1'b1);
    wait_valid("te.first_valid");
    read_chan(80, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(81, 1'b0, 1'b0, 1'b0, 1'b1);
    read_chan(82, 1'b1, 1'b0, 1'b1, 1'b0);

    CHANNEL_SIZE = 9'd0;
    load_start = 1'b1;
    step();
    chk1("cfg0.cfg_err", cfg_err, 1'b1);
    chk1("cfg0.tready", axis.s_axis_tready, 1'b0);
    step();
    chk1("cfg0.tready2", axis.s_axis_tready, 1'b0);
    load_start = 1'b0;

    // Reset in the middle of both a read and a load.
    load(2, 70, 1);
    wait_valid("mid.g_valid");
    CHANNEL_SIZE = 9'd5;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk1("mid.accept", axis.s_axis_tready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata = mk(90 + i);
      step();
    end
    Reset = 1'b0;
    step();
    axis.s_axis_tvalid = 1'b0;
    chk_all_zero("midreset");
    Reset = 1'b1;
    step();

    // Fresh full-depth set after reset.
    load(256, 100, 255);
    wait_valid("full.first_valid");
    for (int i = 0; i < 256; i++)
      read_chan(100 + i, (i == 255), 1'b0, (i == 255), (i != 255));
    chk("full.bank_valid_end", DW'(bank_valid), '0);
    chk1("full.tlast_err", tlast_err, 1'b0);

    CHANNEL_SIZE = 9'd257;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk1("cfg257.cfg_err", cfg_err, 1'b1);
    chk1("cfg257.tready", axis.s_axis_tready, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
